lc3b_sequencer: RTL and testbench
=================================

LC3B_SEQUENCER -- requirements
Module: lc3b_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 run  in  1  start/continue; sampled only in IDLE and at instruction boundaries.
REQ-004 IR  in  16  current instruction register contents; opcode = IR[15:12].
REQ-005 N, Z, P  in  1 each  condition codes from datapath.
REQ-006 mem_ack  in  1  memory completion; ignored while mem_req=0.
REQ-007 state_id  out  5  current state code; drives the datapath decoder.
REQ-008 mem_req  out  1  memory access request (Moore, decoded from state).
REQ-009 mem_we  out  1  write strobe; 1 only in MEM_WR.
REQ-010 instr_done  out  1  one-cycle retire pulse, registered.
REQ-011 retired_cnt  out  16  retired-instruction count.
REQ-012 halted  out  1  1 while in HALT.
REQ-013 timeout_err  out  1  sticky; set when a memory wait times out.

Function
REQ-014 States/codes SHALL be: IDLE=0, FETCH=1, DECODE=2, ALU=3, JMP=4, LEA=5, JSR_LINK=7, BR_TAKEN=9, MEM_RD=10, LD_ADDR=12, LD_WB=13, TRAP_VEC=15, TRAP_JMP=16, MEM_WR=17, ST_ADDR=18, HALT=31.
REQ-015 IDLE: run=1 -> FETCH, else stay.
REQ-016 FETCH/MEM_RD/MEM_WR: mem_req=1; hold state until mem_ack=1 sampled; ack in first request cycle accepted (minimum 1 cycle per memory state).
REQ-017 FETCH on ack -> DECODE.
REQ-018 DECODE by opcode: 0001/0101/1001/1101 -> ALU; 0000 -> BR_TAKEN if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), else instruction ends; 1100 -> JMP; 0100 -> JSR_LINK; 0110/0010 -> LD_ADDR; 0111/0011 -> ST_ADDR; 1110 -> LEA; 1111 -> TRAP_VEC; 1000/1010/1011 -> HALT.
REQ-019 Sequences: LD_ADDR -> MEM_RD -> LD_WB; ST_ADDR -> MEM_WR; JSR_LINK -> JMP; TRAP_VEC -> MEM_RD-free TRAP_JMP; each single-cycle non-memory state advances unconditionally.
REQ-020 Instruction end (ALU, JMP, LEA, BR_TAKEN, LD_WB, MEM_WR on ack, TRAP_JMP, DECODE with BR not taken): next state = FETCH if run=1, else IDLE.
REQ-021 instr_done SHALL be 1 for exactly the cycle after each instruction-end edge; retired_cnt increments on that same edge, wraps 0xFFFF -> 0x0000.
REQ-022 8-bit wait counter: cleared on entry to any memory state, increments each cycle in a memory state with mem_ack=0.
REQ-023 Counter at 255 with mem_ack=0 -> HALT, timeout_err=1; mem_ack=1 at count 255 SHALL win (normal transition).
REQ-024 HALT: absorbing until reset; mem_req=0, halted=1; run ignored.
REQ-025 mem_we SHALL never be 1 outside MEM_WR; mem_req and state_id glitch-free (registered state decode only).
REQ-026 IR, N/Z/P SHALL be evaluated only in DECODE; changes elsewhere have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force state_id=0, mem_req=0, mem_we=0, instr_done=0, retired_cnt=0, halted=0, timeout_err=0, wait counter=0, including mid-memory-access.
REQ-028 After rst_n rises, first transition SHALL occur on the first rising clk edge with run=1.

Verification
REQ-029 run=1, IR=0x1042 (ADD), ack in 1 cycle -> states 1,2,3,1; instr_done one cycle; retired_cnt=1.
REQ-030 IR=0x6000 (LDW), ack delayed 3 cycles in MEM_RD -> 1,2,12,10x4,13,1; mem_we=0 throughout.
REQ-031 IR=0x0400 (BRz), Z=0 -> DECODE directly to FETCH, retired_cnt+1; with Z=1 -> visits 9.
REQ-032 FETCH with mem_ack held 0 for 256 cycles -> HALT (31), timeout_err=1, halted=1; repeat with ack at count 255 -> DECODE, no error.
REQ-033 IR=0x8000 -> HALT; run toggling ignored; rst_n pulse low mid-MEM_WR -> all outputs zero asynchronously, state 0.
REQ-034 Preload 0xFFFF retirements (or force) -> next retire wraps retired_cnt to 0x0000; run=0 at end -> IDLE.

Source files
------------

// File: rtl/lc3b_sequencer.sv
// ---------------------------------------------------------------------------
// lc3b_sequencer
//
// Control sequencer for an LC-3b style multicycle datapath. It steps through
// fetch, decode and per-opcode execute states. It handles memory handshakes
// with a bounded wait, and it counts retired instructions.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   start/continue, sampled in IDLE and at instruction end
//   IR[15:0]     in   instruction register, opcode = IR[15:12]
//   N, Z, P      in   condition codes, only looked at in DECODE
//   mem_ack      in   memory completion, only looked at in memory states
//   state_id[4:0] out current state code for the datapath decoder
//   mem_req      out  memory request (FETCH, MEM_RD, MEM_WR)
//   mem_we       out  write strobe, MEM_WR only
//   instr_done   out  one-cycle retire pulse
//   retired_cnt  out  16-bit wrapping retire count
//   halted       out  high while in HALT
//   timeout_err  out  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module lc3b_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        mem_ack,
    output logic [4:0]  state_id,
    output logic        mem_req,
    output logic        mem_we,
    output logic        instr_done,
    output logic [15:0] retired_cnt,
    output logic        halted,
    output logic        timeout_err
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_ALU      = 5'd3,
        S_JMP      = 5'd4,
        S_LEA      = 5'd5,
        S_JSR_LINK = 5'd7,
        S_BR_TAKEN = 5'd9,
        S_MEM_RD   = 5'd10,
        S_LD_ADDR  = 5'd12,
        S_LD_WB    = 5'd13,
        S_TRAP_VEC = 5'd15,
        S_TRAP_JMP = 5'd16,
        S_MEM_WR   = 5'd17,
        S_ST_ADDR  = 5'd18,
        S_HALT     = 5'd31
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'd255;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        halted_q, halted_d;
    logic        instr_done_q, instr_done_d;
    logic [15:0] retired_cnt_q, retired_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic        instr_end;
    logic        timeout_hit;
    logic        br_taken;
    state_t      boundary_state;
    logic        unused_ir_bits;

    // Only the opcode and the BR condition mask are used by the sequencer.
    assign unused_ir_bits = ^IR[8:0];

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        instr_end      = 1'b0;
        timeout_hit    = 1'b0;
        br_taken       = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
        boundary_state = run ? S_FETCH : S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // An ack in the last allowed cycle still counts as success.
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end

            S_DECODE: begin
                case (IR[15:12])
                    4'b0001, 4'b0101, 4'b1001, 4'b1101: state_d = S_ALU;
                    4'b0000: begin
                        if (br_taken) begin
                            state_d = S_BR_TAKEN;
                        end else begin
                            // Untaken branch retires straight out of DECODE.
                            state_d   = boundary_state;
                            instr_end = 1'b1;
                        end
                    end
                    4'b1100:          state_d = S_JMP;
                    4'b0100:          state_d = S_JSR_LINK;
                    4'b0110, 4'b0010: state_d = S_LD_ADDR;
                    4'b0111, 4'b0011: state_d = S_ST_ADDR;
                    4'b1110:          state_d = S_LEA;
                    4'b1111:          state_d = S_TRAP_VEC;
                    default:          state_d = S_HALT;
                endcase
            end

            S_ALU, S_JMP, S_LEA, S_BR_TAKEN, S_LD_WB, S_TRAP_JMP: begin
                state_d   = boundary_state;
                instr_end = 1'b1;
            end

            S_JSR_LINK: state_d = S_JMP;
            S_LD_ADDR:  state_d = S_MEM_RD;
            S_ST_ADDR:  state_d = S_MEM_WR;
            S_TRAP_VEC: state_d = S_TRAP_JMP;

            S_MEM_RD: begin
                if (mem_ack) begin
                    state_d = S_LD_WB;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end

            S_MEM_WR: begin
                if (mem_ack) begin
                    state_d   = boundary_state;
                    instr_end = 1'b1;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_HALT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Wait counter and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        wait_d = wait_q;
        // A fresh memory access always starts counting from zero.
        if (is_mem_state(state_d) && (state_d != state_q)) begin
            wait_d = 8'd0;
        end else if (is_mem_state(state_q) && !mem_ack && !timeout_hit) begin
            wait_d = wait_q + 8'd1;
        end

        // Outputs are decoded from the next state and registered, so they
        // switch cleanly together with state_id.
        mem_req_d     = is_mem_state(state_d);
        mem_we_d      = (state_d == S_MEM_WR);
        halted_d      = (state_d == S_HALT);
        instr_done_d  = instr_end;
        retired_cnt_d = retired_cnt_q + {15'd0, instr_end};
        timeout_err_d = timeout_err_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_q        <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            halted_q      <= 1'b0;
            instr_done_q  <= 1'b0;
            retired_cnt_q <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            halted_q      <= halted_d;
            instr_done_q  <= instr_done_d;
            retired_cnt_q <= retired_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign state_id    = state_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign halted      = halted_q;
    assign instr_done  = instr_done_q;
    assign retired_cnt = retired_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lc3b_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lc3b_sequencer
//
// Self-checking bench for lc3b_sequencer. The reference model turns an
// instruction into the list of states it should visit. It does this from the
// opcode table and the memory wait lengths. The bench then walks that list
// cycle by cycle. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lc3b_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] IR;
    logic        N;
    logic        Z;
    logic        P;
    logic        mem_ack;
    logic [4:0]  state_id;
    logic        mem_req;
    logic        mem_we;
    logic        instr_done;
    logic [15:0] retired_cnt;
    logic        halted;
    logic        timeout_err;

    int nchk = 0;
    int nfail = 0;
    int exp_cnt = 0;
    bit exp_done = 0;

    lc3b_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .IR          (IR),
        .N           (N),
        .Z           (Z),
        .P           (P),
        .mem_ack     (mem_ack),
        .state_id    (state_id),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .instr_done  (instr_done),
        .retired_cnt (retired_cnt),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset, then raise run so the next falling edge sees FETCH.
    task automatic reset_and_start();
        @(negedge clk);
        run     = 1'b0;
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_cnt  = 0;
        exp_done = 0;
        run      = 1'b1;
        @(negedge clk);
    endtask

    // Run one instruction starting with the DUT in FETCH. d_fetch and d_mem
    // are the number of un-acked cycles before the ack arrives.
    task automatic exec_instr(input logic [15:0] ir, input logic [2:0] nzp,
                              input int d_fetch, input int d_mem, input bit run_end);
        int path[$];
        int trace[$];
        bit acks[$];
        bit halt_path;
        bit taken;
        bit last;
        int s;
        taken = (ir[11] && nzp[2]) || (ir[10] && nzp[1]) || (ir[9] && nzp[0]);
        path.push_back(2);
        case (ir[15:12])
            4'h1, 4'h5, 4'h9, 4'hD: path.push_back(3);
            4'h0: if (taken) path.push_back(9);
            4'hC: path.push_back(4);
            4'h4: begin path.push_back(7); path.push_back(4); end
            4'h6, 4'h2: begin path.push_back(12); path.push_back(10); path.push_back(13); end
            4'h7, 4'h3: begin path.push_back(18); path.push_back(17); end
            4'hE: path.push_back(5);
            4'hF: begin path.push_back(15); path.push_back(16); end
            default: path.push_back(31);
        endcase
        for (int i = 0; i <= d_fetch; i++) begin
            trace.push_back(1);
            acks.push_back(i == d_fetch);
        end
        foreach (path[j]) begin
            if (path[j] == 10 || path[j] == 17) begin
                for (int i = 0; i <= d_mem; i++) begin
                    trace.push_back(path[j]);
                    acks.push_back(i == d_mem);
                end
            end else begin
                trace.push_back(path[j]);
                acks.push_back(1'($urandom));
            end
        end
        halt_path = (path[path.size()-1] == 31);

        for (int i = 0; i < trace.size(); i++) begin
            s    = trace[i];
            last = (i == trace.size() - 1) && !halt_path;
            IR        = (s == 2) ? ir : 16'($urandom);
            {N, Z, P} = (s == 2) ? nzp : 3'($urandom);
            mem_ack   = acks[i];
            run       = last ? run_end : 1'($urandom);
            nchk++;
            if (state_id !== 5'(s) || mem_req !== (s == 1 || s == 10 || s == 17) ||
                mem_we !== (s == 17) || halted !== (s == 31) || timeout_err !== 1'b0) begin
                nfail++;
                $display("FAIL seq_state ir=%h step %0d: state=%0d req=%b we=%b halted=%b terr=%b, expected state %0d",
                         ir, i, state_id, mem_req, mem_we, halted, timeout_err, s);
            end
            nchk++;
            if (instr_done !== exp_done) begin
                nfail++;
                $display("FAIL instr_done ir=%h step %0d: got %b expected %b", ir, i, instr_done, exp_done);
            end
            nchk++;
            if (retired_cnt !== 16'(exp_cnt)) begin
                nfail++;
                $display("FAIL retired_cnt ir=%h step %0d: got %h expected %h", ir, i, retired_cnt, 16'(exp_cnt));
            end
            @(negedge clk);
            exp_done = last;
            if (last) exp_cnt = (exp_cnt + 1) % 65536;
        end

        if (!halt_path && !run_end) begin
            nchk++;
            if (state_id !== 5'd0 || instr_done !== 1'b1 || retired_cnt !== 16'(exp_cnt)) begin
                nfail++;
                $display("FAIL idle_entry: state=%0d done=%b cnt=%h, expected state 0 done 1 cnt %h",
                         state_id, instr_done, retired_cnt, 16'(exp_cnt));
            end
            run = 1'b0;
            @(negedge clk);
            exp_done = 0;
            nchk++;
            if (state_id !== 5'd0 || instr_done !== 1'b0) begin
                nfail++;
                $display("FAIL idle_hold: state=%0d done=%b, expected state 0 done 0", state_id, instr_done);
            end
            run = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; run = 1'b0; mem_ack = 1'b0; IR = 16'h0; {N, Z, P} = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({state_id, mem_req, mem_we, instr_done, retired_cnt, halted, timeout_err} !== 26'd0) begin
            nfail++;
            $display("FAIL reset_values: state=%0d req=%b we=%b done=%b cnt=%h halted=%b terr=%b, expected all zero",
                     state_id, mem_req, mem_we, instr_done, retired_cnt, halted, timeout_err);
        end
        run = 1'b1;
        @(negedge clk);
        nchk++;
        if (state_id !== 5'd0) begin
            nfail++;
            $display("FAIL reset_hold: state=%0d expected 0", state_id);
        end
        run   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchk++;
            if (state_id !== 5'd0 || mem_req !== 1'b0) begin
                nfail++;
                $display("FAIL idle_no_run: state=%0d req=%b expected state 0 req 0", state_id, mem_req);
            end
        end
        run = 1'b1;
        @(negedge clk);
        nchk++;
        if (state_id !== 5'd1 || mem_req !== 1'b1) begin
            nfail++;
            $display("FAIL first_fetch: state=%0d req=%b expected state 1 req 1", state_id, mem_req);
        end
    endtask

    task automatic test_add();
        reset_and_start();
        exec_instr(16'h1042, 3'b000, 0, 0, 1'b1);
        exec_instr(16'h1042, 3'b111, 2, 0, 1'b1);
    endtask

    task automatic test_ldw();
        reset_and_start();
        exec_instr(16'h6000, 3'b000, 0, 3, 1'b1);
        exec_instr(16'h7000, 3'b000, 1, 2, 1'b0);
    endtask

    task automatic test_br();
        reset_and_start();
        exec_instr(16'h0400, 3'b101, 0, 0, 1'b1);
        exec_instr(16'h0400, 3'b010, 0, 0, 1'b1);
        exec_instr(16'h0E00, 3'b000, 0, 0, 1'b1);
    endtask

    task automatic test_timeout();
        reset_and_start();
        for (int i = 0; i < 256; i++) begin
            mem_ack = 1'b0;
            nchk++;
            if (state_id !== 5'd1 || timeout_err !== 1'b0) begin
                nfail++;
                $display("FAIL timeout_wait cycle %0d: state=%0d terr=%b expected state 1 terr 0",
                         i, state_id, timeout_err);
            end
            @(negedge clk);
        end
        nchk++;
        if (state_id !== 5'd31 || timeout_err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_halt: state=%0d terr=%b halted=%b req=%b expected 31 1 1 0",
                     state_id, timeout_err, halted, mem_req);
        end
    endtask

    task automatic test_timeout_ack_wins();
        reset_and_start();
        exec_instr(16'h1042, 3'b000, 255, 0, 1'b1);
        exec_instr(16'h6000, 3'b000, 0, 255, 1'b1);
    endtask

    task automatic test_halt_instr();
        reset_and_start();
        exec_instr(16'h1042, 3'b000, 0, 0, 1'b1);
        exec_instr(16'h8000, 3'b000, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run     = i[0];
            mem_ack = 1'($urandom);
            IR      = 16'($urandom);
            nchk++;
            if (state_id !== 5'd31 || halted !== 1'b1 || mem_req !== 1'b0 ||
                instr_done !== 1'b0 || retired_cnt !== 16'd1) begin
                nfail++;
                $display("FAIL halt_absorb cycle %0d: state=%0d halted=%b req=%b done=%b cnt=%h expected 31 1 0 0 0001",
                         i, state_id, halted, mem_req, instr_done, retired_cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        reset_and_start();
        exec_instr(16'h1042, 3'b000, 0, 0, 1'b1);
        mem_ack = 1'b1;
        @(negedge clk);
        IR      = 16'h7000;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nchk++;
        if (state_id !== 5'd17 || mem_we !== 1'b1 || mem_req !== 1'b1 || retired_cnt !== 16'd1) begin
            nfail++;
            $display("FAIL mem_wr_entry: state=%0d we=%b req=%b cnt=%h expected 17 1 1 0001",
                     state_id, mem_we, mem_req, retired_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({state_id, mem_req, mem_we, instr_done, retired_cnt, halted, timeout_err} !== 26'd0) begin
            nfail++;
            $display("FAIL async_reset_mid_wr: state=%0d req=%b we=%b done=%b cnt=%h halted=%b terr=%b, expected all zero",
                     state_id, mem_req, mem_we, instr_done, retired_cnt, halted, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random_stream();
        logic [3:0] op;
        reset_and_start();
        for (int k = 0; k < 40; k++) begin
            do op = 4'($urandom); while (op == 4'h8 || op == 4'hA || op == 4'hB);
            exec_instr({op, 12'($urandom)}, 3'($urandom), $urandom_range(0, 3),
                       $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_wrap();
        reset_and_start();
        force dut.retired_cnt_q = 16'hFFFE;
        #1 release dut.retired_cnt_q;
        exp_cnt = 16'hFFFE;
        exec_instr(16'h0400, 3'b000, 0, 0, 1'b1);
        exec_instr(16'h1042, 3'b000, 0, 0, 1'b0);
        nchk++;
        if (retired_cnt !== 16'h0000 || exp_cnt != 0) begin
            nfail++;
            $display("FAIL retired_wrap: got %h expected 0000", retired_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldw();
        test_br();
        test_timeout();
        test_timeout_ack_wins();
        test_halt_instr();
        test_reset_mid_write();
        test_random_stream();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
